// File: rtl/guess_pkg.sv
// Shared definitions for the guessing game: comparator result codes, FSM
// state codes and small try-counter helpers. Also used by the comparator and
// the LCD message stage.
package guess_pkg;

  localparam int unsigned TRY_W = 4;
  localparam int unsigned CMP_W = 2;

  localparam logic [CMP_W-1:0] CMP_EQ   = 2'b00;
  localparam logic [CMP_W-1:0] CMP_LOW  = 2'b01;
  localparam logic [CMP_W-1:0] CMP_HIGH = 2'b10;
  localparam logic [CMP_W-1:0] CMP_BAD  = 2'b11;

  localparam logic [TRY_W-1:0] TRY_MAX = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_EVAL   = 3'd3,
    ST_WIN    = 3'd4,
    ST_LOSE   = 3'd5
  } state_t;

  // Increment that sticks at the top code instead of wrapping
  function automatic logic [TRY_W-1:0] sat_inc(input logic [TRY_W-1:0] v);
    return (v == TRY_MAX) ? v : v + TRY_W'(1);
  endfunction

  // Remaining tries; zero when unlimited or when the count has caught up
  function automatic logic [TRY_W-1:0] tries_remaining(input logic [TRY_W-1:0] limit,
                                                       input logic [TRY_W-1:0] used);
    return (limit > used) ? limit - used : '0;
  endfunction

endpackage

// File: rtl/button_sync.sv
// Pushbutton front end: 2-flop synchronizer, stable-count debouncer and a
// single-cycle pulse on the debounced press (falling) edge.
module button_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press_c
);

  logic [1:0]       sync;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain; idle level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], btn_n};
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
    end else begin
      stable_d <= stable;
      if (sync[1] != stable) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable <= sync[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press_c = stable_d & ~stable;

endmodule

// File: rtl/guess_round_fsm.sv
// Game sequencer downstream of the secret/guess comparator: debounces the
// buttons, strobes guess_latch, waits for the comparator, scores the guess
// and drives status plus an LCD refresh pulse.
// Optional feature macro: BEST_SCORE_EN adds the best_tries output.
module guess_round_fsm
  import guess_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned SETTLE_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_new_n,
  input  logic       btn_guess_n,
  input  logic [1:0] cmp_result,
  input  logic [3:0] max_tries,
  output logic       guess_latch,
  output logic [3:0] tries_used,
  output logic [3:0] tries_left,
  output logic [1:0] hint,
  output logic [2:0] game_state,
  output logic       win,
  output logic       lose,
  output logic       lcd_refresh
`ifdef BEST_SCORE_EN
  ,
  output logic [3:0] best_tries
`endif
);

  localparam int unsigned SET_W = 3;

  logic [1:0]       rst_sync;
  logic             rst_n;
  logic             new_p;
  logic             guess_p;

  state_t           state,       state_n;
  logic [SET_W-1:0] settle_cnt,  settle_cnt_n;
  logic [TRY_W-1:0] limit,       limit_n;
  logic [TRY_W-1:0] tries_n;
  logic [TRY_W-1:0] tries_left_n;
  logic [TRY_W-1:0] tries_inc;
  logic [CMP_W-1:0] hint_n;
  logic             latch_n;
  logic             refresh_n;
  logic             win_n;
  logic             lose_n;
`ifdef BEST_SCORE_EN
  logic [TRY_W-1:0] best_n;
`endif

  // Reset asserts asynchronously and releases two clocks later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  button_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn_new (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n   (btn_new_n),
    .press_c (new_p)
  );

  button_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn_guess (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n   (btn_guess_n),
    .press_c (guess_p)
  );

  assign tries_inc  = sat_inc(tries_used);
  assign game_state = state;

  // State and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      settle_cnt  <= '0;
      limit       <= '0;
      tries_used  <= '0;
      tries_left  <= '0;
      hint        <= CMP_BAD;
      guess_latch <= 1'b0;
      lcd_refresh <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
`ifdef BEST_SCORE_EN
      best_tries  <= TRY_MAX;
`endif
    end else begin
      state       <= state_n;
      settle_cnt  <= settle_cnt_n;
      limit       <= limit_n;
      tries_used  <= tries_n;
      tries_left  <= tries_left_n;
      hint        <= hint_n;
      guess_latch <= latch_n;
      lcd_refresh <= refresh_n;
      win         <= win_n;
      lose        <= lose_n;
`ifdef BEST_SCORE_EN
      best_tries  <= best_n;
`endif
    end
  end

  // Next-state and next-status decode; a new-game press overrides everything
  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    limit_n      = limit;
    tries_n      = tries_used;
    hint_n       = hint;
    latch_n      = 1'b0;
    refresh_n    = 1'b0;
`ifdef BEST_SCORE_EN
    best_n       = best_tries;
`endif

    if (new_p) begin
      state_n      = ST_ARMED;
      settle_cnt_n = '0;
      limit_n      = max_tries;
      tries_n      = '0;
      hint_n       = CMP_BAD;
      refresh_n    = 1'b1;
    end else begin
      case (state)
        ST_ARMED: begin
          if (guess_p) begin
            latch_n      = 1'b1;
            settle_cnt_n = '0;
            state_n      = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
            state_n = ST_EVAL;
          end else begin
            settle_cnt_n = settle_cnt + SET_W'(1);
          end
        end
        ST_EVAL: begin
          refresh_n = 1'b1;
          case (cmp_result)
            CMP_EQ: begin
              tries_n = tries_inc;
              hint_n  = CMP_EQ;
              state_n = ST_WIN;
`ifdef BEST_SCORE_EN
              if (tries_inc < best_tries) begin
                best_n = tries_inc;
              end
`endif
            end
            CMP_LOW, CMP_HIGH: begin
              tries_n = tries_inc;
              hint_n  = cmp_result;
              if ((limit != '0) && (tries_inc == limit)) begin
                state_n = ST_LOSE;
              end else begin
                state_n = ST_ARMED;
              end
            end
            default: begin
              hint_n  = CMP_BAD;
              state_n = ST_ARMED;
            end
          endcase
        end
        default: begin
        end
      endcase
    end

    win_n        = (state_n == ST_WIN);
    lose_n       = (state_n == ST_LOSE);
    tries_left_n = tries_remaining(limit_n, tries_n);
  end

endmodule

// File: tb/tb_guess_round_fsm.sv
// Directed bench for guess_round_fsm with a status scoreboard fed by a small
// behavioural game model. Build with +define+BEST_SCORE_EN to cover best_tries.
module tb_guess_round_fsm;

  logic       clk;
  logic       reset;
  logic       btn_new_n;
  logic       btn_guess_n;
  logic [1:0] cmp_result;
  logic [3:0] max_tries;
  logic       guess_latch;
  logic [3:0] tries_used;
  logic [3:0] tries_left;
  logic [1:0] st_hint;
  logic [2:0] game_state;
  logic       win;
  logic       lose;
  logic       lcd_refresh;
`ifdef BEST_SCORE_EN
  logic [3:0] best_tries;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int latch_seen  = 0;
  int latch_exp   = 0;
  int refresh_seen = 0;

  logic [15:0] exp_q[$];

  // Behavioural game model
  int m_state = 0;
  int m_tries = 0;
  int m_limit = 0;
  int m_hint  = 3;
  int m_best  = 15;

  guess_round_fsm #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (4),
    .SETTLE_CYCLES   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_new_n   (btn_new_n),
    .btn_guess_n (btn_guess_n),
    .cmp_result  (cmp_result),
    .max_tries   (max_tries),
    .guess_latch (guess_latch),
    .tries_used  (tries_used),
    .tries_left  (tries_left),
    .hint        (st_hint),
    .game_state  (game_state),
    .win         (win),
    .lose        (lose),
    .lcd_refresh (lcd_refresh)
`ifdef BEST_SCORE_EN
    ,
    .best_tries  (best_tries)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack_status(input int t, input int h, input int st, input int lim);
    int left;
    left = (lim > t) ? lim - t : 0;
    return {4'h0, 4'(t), 2'(h), (st == 4), (st == 5), 4'(left)};
  endfunction

  task automatic push_model();
    exp_q.push_back(pack_status(m_tries, m_hint, m_state, m_limit));
  endtask

  task automatic model_reset();
    m_state = 0;
    m_tries = 0;
    m_limit = 0;
    m_hint  = 3;
  endtask

  task automatic model_new(input int mt);
    m_state = 1;
    m_tries = 0;
    m_limit = mt;
    m_hint  = 3;
    push_model();
  endtask

  task automatic model_guess(input int cmp);
    if (m_state != 1) return;
    latch_exp++;
    if (cmp == 3) begin
      m_hint = 3;
      m_state = 1;
    end else begin
      m_tries = (m_tries == 15) ? 15 : m_tries + 1;
      m_hint  = cmp;
      if (cmp == 0) begin
        m_state = 4;
        if (m_tries < m_best) m_best = m_tries;
      end else if (m_limit != 0 && m_tries == m_limit) begin
        m_state = 5;
      end else begin
        m_state = 1;
      end
    end
    push_model();
  endtask

  // which: 0 = new, 1 = guess, 2 = both together
  task automatic press_btn(input int which, input int n);
    @(negedge clk);
    if (which != 1) btn_new_n = 1'b0;
    if (which != 0) btn_guess_n = 1'b0;
    repeat (n) @(negedge clk);
    btn_new_n   = 1'b1;
    btn_guess_n = 1'b1;
    repeat (14) @(negedge clk);
  endtask

  task automatic new_game(input int mt);
    max_tries = 4'(mt);
    model_new(mt);
    press_btn(0, 10);
  endtask

  task automatic guess(input int cmp);
    cmp_result = 2'(cmp);
    model_guess(cmp);
    press_btn(1, 10);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".tries_used"}, 16'(tries_used), 16'(m_tries));
    check({tag, ".tries_left"}, 16'(tries_left), 16'((m_limit > m_tries) ? m_limit - m_tries : 0));
    check({tag, ".hint"},       16'(st_hint),    16'(m_hint));
    check({tag, ".game_state"}, 16'(game_state), 16'(m_state));
    check({tag, ".win"},        16'(win),        16'(m_state == 4));
    check({tag, ".lose"},       16'(lose),       16'(m_state == 5));
    check({tag, ".latches"},    16'(latch_seen), 16'(latch_exp));
`ifdef BEST_SCORE_EN
    check({tag, ".best_tries"}, 16'(best_tries), 16'(m_best));
`endif
  endtask

  task automatic win_in(input int n);
    new_game(0);
    for (int i = 0; i < n - 1; i++) guess((i % 2 == 0) ? 1 : 2);
    guess(0);
  endtask

  // Scoreboard consumer: every refresh must match the next expected status
  always @(negedge clk) begin
    if (guess_latch) latch_seen++;
    if (lcd_refresh) begin
      refresh_seen++;
      if (exp_q.size() == 0) begin
        check("refresh_unexpected", 16'(lcd_refresh), 16'(0));
      end else begin
        check("refresh_status", {4'h0, tries_used, st_hint, win, lose, tries_left}, exp_q.pop_front());
      end
    end
  end

  initial begin
    bit found;
    int ref0;

    reset       = 1'b0;
    btn_new_n   = 1'b1;
    btn_guess_n = 1'b1;
    cmp_result  = 2'b11;
    max_tries   = 4'd0;
    repeat (4) @(negedge clk);
    check("rst.refresh", 16'(lcd_refresh), 16'(0));
    check("rst.latch",   16'(guess_latch), 16'(0));
    check_outputs("rst");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Reset in the middle of SETTLE
    new_game(5);
    cmp_result  = 2'b01;
    @(negedge clk);
    btn_guess_n = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (game_state == 3'd2) found = 1'b1;
    end
    check("settle_reached", 16'(found), 16'(1));
    if (found) latch_exp++;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    btn_guess_n = 1'b1;
    check("midrst.refresh", 16'(lcd_refresh), 16'(0));
    check("midrst.latch",   16'(guess_latch), 16'(0));
    check_outputs("midrst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check_outputs("postrst");

    // Glitch rejection and single strobe for a held press
    new_game(0);
    cmp_result = 2'b01;
    press_btn(1, 3);
    check_outputs("glitch");
    guess(1);
    check_outputs("held_press");

    // Winning game with a limit of three
    new_game(3);
    ref0 = refresh_seen;
    guess(1);
    check_outputs("win.g1");
    guess(2);
    check_outputs("win.g2");
    guess(0);
    check_outputs("win.g3");
    check("win.refreshes", 16'(refresh_seen - ref0), 16'(3));

    // Losing game; further guesses ignored
    new_game(2);
    guess(1);
    guess(1);
    check_outputs("lose");
    guess(1);
    check_outputs("lose.hold");

    // Simultaneous new and guess: new wins
    max_tries = 4'd4;
    model_new(4);
    press_btn(2, 10);
    check_outputs("both");
    guess(3);
    check_outputs("bad_cmp");

`ifdef BEST_SCORE_EN
    win_in(5);
    check_outputs("best.g1");
    win_in(7);
    check_outputs("best.g2");
    win_in(2);
    check_outputs("best.g3");
`endif

    repeat (10) @(negedge clk);
    check("sb_drain", 16'(exp_q.size()), 16'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
